// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode and FSM state encodings for the shared logic unit arbiter
package logic_unit_pkg;

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_XNOR = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - requester/response bundle between issue ports and the arbiter
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/NAND_8.sv
// rtl/NAND_8.sv - bitwise NAND slice
module NAND_8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a & b);
endmodule

// File: rtl/NOR_8.sv
// rtl/NOR_8.sv - bitwise NOR slice
module NOR_8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/XNOR_8.sv
// rtl/XNOR_8.sv - bitwise XNOR slice
module XNOR_8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a ^ b);
endmodule

// File: rtl/XOR_8.sv
// rtl/XOR_8.sv - bitwise XOR slice
module XOR_8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic_unit_8.sv
// rtl/logic_unit_8.sv - combinational bitwise logic unit, all four gates evaluated and muxed on op
module logic_unit_8
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W-1:0] yXor, yNand, yXnor, yNor;

  XOR_8  #(.W(W)) uXor  (.a(a), .b(b), .y(yXor));
  NAND_8 #(.W(W)) uNand (.a(a), .b(b), .y(yNand));
  XNOR_8 #(.W(W)) uXnor (.a(a), .b(b), .y(yXnor));
  NOR_8  #(.W(W)) uNor  (.a(a), .b(b), .y(yNor));

  always_comb begin
    y = yXor;
    case (op)
      OP_XOR:  y = yXor;
      OP_NAND: y = yNand;
      OP_XNOR: y = yXnor;
      OP_NOR:  y = yNor;
      default: y = yXor;
    endcase
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin share of one bitwise logic unit between NUM_REQ requesters
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, nextState;
  logic [ID_W-1:0]      lastGrant, grantId, capId, rspId;
  logic [1:0]           capOp, selOp;
  logic [DATA_W-1:0]    capA, capB, selA, selB, luResult, rspData;
  logic [NUM_REQ-1:0]   readyVec;
  logic                 anyValid;

  // First valid index after last, wrapping; candidate sum stays below 2*NUM_REQ so one subtract suffices.
  function automatic logic [ID_W-1:0] pickNext(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W:0]   cand;
    logic [ID_W-1:0] win;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && valid[cand[ID_W-1:0]]) begin
        win   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign anyValid = |bus.req_valid;

  always_comb begin
    grantId = pickNext(bus.req_valid, lastGrant);
    selOp   = '0;
    selA    = '0;
    selB    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantId == ID_W'(i)) begin
        selOp = bus.req_op[2*i +: 2];
        selA  = bus.req_a[DATA_W*i +: DATA_W];
        selB  = bus.req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    nextState = state;
    readyVec  = '0;
    case (state)
      ST_IDLE: begin
        if (anyValid) begin
          readyVec[grantId] = 1'b1;
          nextState         = ST_EXEC;
        end
      end
      ST_EXEC: nextState = ST_RESP;
      ST_RESP: if (bus.rsp_ready) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant <= ID_W'(NUM_REQ-1);
      capId     <= '0;
      capOp     <= '0;
      capA      <= '0;
      capB      <= '0;
      rspData   <= '0;
      rspId     <= '0;
    end else begin
      if (state == ST_IDLE && anyValid) begin
        capId     <= grantId;
        capOp     <= selOp;
        capA      <= selA;
        capB      <= selB;
        lastGrant <= grantId;
      end
      if (state == ST_EXEC) begin
        rspData <= luResult;
        rspId   <= capId;
      end
    end
  end

  logic_unit_8 #(.W(DATA_W)) uLogicUnit (
    .op (capOp),
    .a  (capA),
    .b  (capB),
    .y  (luResult)
  );

  // rsp_valid decodes from state so it drops together with the async reset.
  assign bus.req_ready = readyVec;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = rspData;
  assign bus.rsp_id    = rspId;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed scoreboard bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [7:0] opA[4];
  logic [7:0] opB[4];
  logic [7:0] t2Exp[4];
  logic [7:0] stallExp;
  int         order[5];

  logic_unit_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  logic_unit_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] luModel(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return ~(a & b);
      2'b10:   return ~(a ^ b);
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int idx, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic v);
    bus.req_op[2*idx +: 2] = op;
    bus.req_a[8*idx +: 8]  = a;
    bus.req_b[8*idx +: 8]  = b;
    bus.req_valid[idx]     = v;
  endtask

  task automatic expectResp(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_data"}, bus.rsp_data, e.data);
      check({tag, "_rsp_id"}, bus.rsp_id, e.id);
    end
  endtask

  initial begin
    int cyc, lastCyc, n;
    t2Exp[0] = 8'h33; t2Exp[1] = 8'hF3; t2Exp[2] = 8'hCC; t2Exp[3] = 8'hC0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // single op on req0
    @(negedge clk);
    setReq(0, 2'b00, 8'h3F, 8'hF2, 1'b1);
    #1;
    check("t1_ready", bus.req_ready, 4'b0001);
    sb.push_back('{2'd0, 8'hCD});
    @(negedge clk);
    setReq(0, 2'b00, 8'h00, 8'h00, 1'b0);
    check("t1_exec_busy", bus.busy, 1);
    check("t1_exec_no_valid", bus.rsp_valid, 0);
    check("t1_exec_ready", bus.req_ready, 0);
    @(negedge clk);
    expectResp("t1", 0);

    // every opcode through req1
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      setReq(1, 2'(k), 8'h0F, 8'h3C, 1'b1);
      #1;
      check("t2_ready", bus.req_ready, 4'b0010);
      sb.push_back('{2'd1, t2Exp[k]});
      @(negedge clk);
      setReq(1, 2'b00, 8'h00, 8'h00, 1'b0);
      expectResp("t2", 4);
    end

    // req3 alone twice: second grant wraps from last_grant=3 back to 3
    @(negedge clk);
    setReq(3, 2'b11, 8'h81, 8'h18, 1'b1);
    #1;
    check("t6_first_ready", bus.req_ready, 4'b1000);
    sb.push_back('{2'd3, 8'h66});
    @(negedge clk);
    setReq(3, 2'b01, 8'hAA, 8'h0F, 1'b1);
    expectResp("t6a", 4);
    @(negedge clk);
    check("t6_wrap_ready", bus.req_ready, 4'b1000);
    sb.push_back('{2'd3, 8'hF5});
    @(negedge clk);
    setReq(3, 2'b00, 8'h00, 8'h00, 1'b0);
    expectResp("t6b", 4);

    // all four valid continuously, rsp_ready high
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      opA[i] = 8'($urandom_range(0, 255));
      opB[i] = 8'($urandom_range(0, 255));
      setReq(i, 2'(i), opA[i], opB[i], 1'b1);
    end
    #1;
    cyc = 0;
    lastCyc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus.req_ready == 4'b0000 && n < 10) begin
        @(negedge clk);
        cyc++;
        n++;
      end
      check("t3_grant", bus.req_ready, 4'b0001 << order[k]);
      if (k > 0) check("t3_gap", cyc - lastCyc, 3);
      lastCyc = cyc;
      sb.push_back('{2'(order[k]), luModel(2'(order[k]), opA[order[k]], opB[order[k]])});
      @(negedge clk);
      cyc++;
      @(negedge clk);
      cyc++;
      expectResp("t3", 0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) setReq(i, 2'b00, 8'h00, 8'h00, 1'b0);

    // consumer stalls for 5 cycles in RESP
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    setReq(2, 2'b10, 8'h5A, 8'hC3, 1'b1);
    #1;
    check("t4_ready", bus.req_ready, 4'b0100);
    stallExp = 8'h66;
    sb.push_back('{2'd2, stallExp});
    @(negedge clk);
    setReq(2, 2'b00, 8'h00, 8'h00, 1'b0);
    setReq(0, 2'b11, 8'h12, 8'h34, 1'b1);
    #1;
    check("t4_exec_ready", bus.req_ready, 0);
    @(negedge clk);
    expectResp("t4", 0);
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_valid", bus.rsp_valid, 1);
      check("t4_stall_data", bus.rsp_data, stallExp);
      check("t4_stall_id", bus.rsp_id, 2);
      check("t4_stall_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_release_no_grant", bus.req_ready, 0);
    @(negedge clk);
    check("t4_after_valid", bus.rsp_valid, 0);
    check("t4_next_grant", bus.req_ready, 4'b0001);
    sb.push_back('{2'd0, 8'hC9});
    @(negedge clk);
    setReq(0, 2'b00, 8'h00, 8'h00, 1'b0);
    expectResp("t4b", 4);

    // reset while req2 is in EXEC
    @(negedge clk);
    setReq(2, 2'b01, 8'hF0, 8'h3C, 1'b1);
    #1;
    check("t5_ready", bus.req_ready, 4'b0100);
    @(negedge clk);
    setReq(2, 2'b00, 8'h00, 8'h00, 1'b0);
    check("t5_exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus.rsp_valid, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_data", bus.rsp_data, 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_no_rsp", bus.rsp_valid, 0);
    end
    rst_n = 1'b1;
    setReq(0, 2'b00, 8'hA5, 8'h5A, 1'b1);
    setReq(2, 2'b11, 8'h0F, 8'hF0, 1'b1);
    #1;
    check("t5_req0_first", bus.req_ready, 4'b0001);
    sb.push_back('{2'd0, 8'hFF});
    @(negedge clk);
    setReq(0, 2'b00, 8'h00, 8'h00, 1'b0);
    expectResp("t5a", 4);
    @(negedge clk);
    check("t5_req2_next", bus.req_ready, 4'b0100);
    sb.push_back('{2'd2, 8'h00});
    @(negedge clk);
    setReq(2, 2'b00, 8'h00, 8'h00, 1'b0);
    expectResp("t5b", 4);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
